// File: rtl/adc_frame_streamer_pkg.sv
// Shared definitions for adc_frame_streamer: FSM state codes, the frame sync byte,
// and the sample-to-inverted-offset-binary conversion.
package adc_frame_streamer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARM      = 3'd1,
      ST_WAIT_EOC = 3'd2,
      ST_LATCH    = 3'd3,
      ST_SEND     = 3'd4,
      ST_GAP      = 3'd5
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // (2^(w-1)-1) - x modulo 2^w; x is zero-extended to 16 bits, result in the low w bits
   function automatic logic [15:0] adc_code(input logic [15:0] x, input int unsigned w);
      logic [15:0] mask;
      logic [15:0] mid;
      mask = 16'((32'd1 << w) - 32'd1);
      mid  = 16'((32'd1 << (w - 32'd1)) - 32'd1);
      return (mid - x) & mask;
   endfunction

endpackage

// File: rtl/adc_frame_streamer_frame_tx_buffer.sv
// Frame buffer and byte serialiser: captures a coded frame, then shifts it out one
// byte per write strobe under the tx_full handshake. Header under ADC_FRAME_HEADER_EN.
module frame_tx_buffer
   import adc_frame_streamer_pkg::*;
#(
   parameter int unsigned SAMPLE_W = 14,
   parameter int unsigned NUM_CH   = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load,
   input  logic                         send,
   input  logic                         tx_full,
   input  logic [NUM_CH*SAMPLE_W-1:0]   coded,
   output logic                         wr,
   output logic [7:0]                   w_data,
   output logic                         frame_done
);

`ifdef ADC_FRAME_HEADER_EN
   localparam int unsigned HDR_BYTES = 2;
`else
   localparam int unsigned HDR_BYTES = 0;
`endif
   localparam int unsigned NBYTES = HDR_BYTES + 2 * NUM_CH;

   logic [NBYTES*8-1:0] frame_q;
   logic [NBYTES*8-1:0] frame_d;
   logic [2:0]          left_q;
   logic [SAMPLE_W-1:0] smp;
`ifdef ADC_FRAME_HEADER_EN
   logic [7:0]          seq_q;
`endif

   // Byte 0 of the frame sits in the low byte so a right shift advances to the next one
   always_comb begin
      frame_d = '0;
      smp     = '0;
`ifdef ADC_FRAME_HEADER_EN
      frame_d[7:0]  = SYNC_BYTE;
      frame_d[15:8] = seq_q;
`endif
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         smp = coded[c*SAMPLE_W +: SAMPLE_W];
         frame_d[(HDR_BYTES + 2*c)*8 +: 8]     = 8'(smp >> 8);
         frame_d[(HDR_BYTES + 2*c + 1)*8 +: 8] = smp[7:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_q <= '0;
         left_q  <= '0;
`ifdef ADC_FRAME_HEADER_EN
         seq_q   <= '0;
`endif
      end else if (load) begin
         frame_q <= frame_d;
         left_q  <= 3'(NBYTES);
`ifdef ADC_FRAME_HEADER_EN
         seq_q   <= seq_q + 8'd1;
`endif
      end else if (wr) begin
         frame_q <= frame_q >> 8;
         left_q  <= left_q - 3'd1;
      end
   end

   assign wr         = send & ~tx_full;
   assign w_data     = frame_q[7:0];
   assign frame_done = (left_q == '0);

endmodule

// File: rtl/adc_frame_streamer.sv
// ADC frame streamer: triggers conversions, decimates, and streams coded samples as
// bytes to a UART FIFO. Optional frame header enabled by macro ADC_FRAME_HEADER_EN.
module adc_frame_streamer
   import adc_frame_streamer_pkg::*;
#(
   parameter int unsigned SAMPLE_W = 14,
   parameter int unsigned NUM_CH   = 2,
   parameter int unsigned DECIM    = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic                end_conv,
   input  logic [SAMPLE_W-1:0] ch0_in,
   input  logic [SAMPLE_W-1:0] ch1_in,
   input  logic                tx_full,
   output logic                wr,
   output logic [7:0]          w_data,
   output logic                conv,
   output logic                busy,
   output logic                overrun,
   output logic [2:0]          state
);

   state_t                      state_q;
   state_t                      state_d;
   logic                        eoc_prev_q;
   logic                        eoc_rise;
   logic [7:0]                  dec_cnt_q;
   logic                        stop_q;
   logic                        overrun_q;
   logic                        load;
   logic                        send;
   logic                        frame_done;
   logic [NUM_CH*SAMPLE_W-1:0]  coded;

   assign eoc_rise = end_conv & ~eoc_prev_q;

   always_comb begin
      coded = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         coded[c*SAMPLE_W +: SAMPLE_W] =
            SAMPLE_W'(adc_code(16'((c == 0) ? ch0_in : ch1_in), SAMPLE_W));
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      send    = 1'b0;
      conv    = 1'b0;
      case (state_q)
         ST_IDLE:     if (start) state_d = ST_ARM;
         ST_ARM: begin
            conv    = 1'b1;
            state_d = ST_WAIT_EOC;
         end
         ST_WAIT_EOC: if (eoc_rise) state_d = ST_LATCH;
         ST_LATCH: begin
            if (dec_cnt_q < 8'(DECIM - 1)) begin
               state_d = ST_ARM;
            end else begin
               load    = 1'b1;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            send = 1'b1;
            if (!tx_full) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (!frame_done)  state_d = ST_SEND;
            else if (stop_q)  state_d = ST_IDLE;
            else              state_d = ST_WAIT_EOC;
         end
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         eoc_prev_q <= 1'b0;
         dec_cnt_q  <= '0;
         stop_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         eoc_prev_q <= end_conv;

         if (state_q == ST_IDLE && start)
            dec_cnt_q <= '0;
         else if (state_q == ST_LATCH)
            dec_cnt_q <= (dec_cnt_q < 8'(DECIM - 1)) ? dec_cnt_q + 8'd1 : '0;

         if (state_q != ST_IDLE && state_d == ST_IDLE)
            stop_q <= 1'b0;
         else if (state_q != ST_IDLE && stop)
            stop_q <= 1'b1;

         // Edges arriving while a frame is being serialised are dropped, not queued
         if (state_q == ST_IDLE && start)
            overrun_q <= 1'b0;
         else if (eoc_rise && (state_q == ST_SEND || state_q == ST_GAP))
            overrun_q <= 1'b1;
      end
   end

   frame_tx_buffer #(
      .SAMPLE_W (SAMPLE_W),
      .NUM_CH   (NUM_CH)
   ) u_frame_tx_buffer (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .send       (send),
      .tx_full    (tx_full),
      .coded      (coded),
      .wr         (wr),
      .w_data     (w_data),
      .frame_done (frame_done)
   );

   assign busy    = (state_q != ST_IDLE);
   assign overrun = overrun_q;
   assign state   = state_q;

endmodule

// File: tb/tb_adc_frame_streamer.sv
// Directed-sequence bench for adc_frame_streamer with randomized samples checked
// against a reference model of the frame format and decimation rule.
module tb_adc_frame_streamer;

   localparam int unsigned SW  = 14;
   localparam int unsigned NC  = 2;
   localparam int unsigned DEC = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          end_conv = 1'b0;
   logic [SW-1:0] ch0_in = '0;
   logic [SW-1:0] ch1_in = '0;
   logic          tx_full = 1'b0;
   logic          wr;
   logic [7:0]    w_data;
   logic          conv;
   logic          busy;
   logic          overrun;
   logic [2:0]    state;

   adc_frame_streamer #(
      .SAMPLE_W (SW),
      .NUM_CH   (NC),
      .DECIM    (DEC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .end_conv (end_conv),
      .ch0_in   (ch0_in),
      .ch1_in   (ch1_in),
      .tx_full  (tx_full),
      .wr       (wr),
      .w_data   (w_data),
      .conv     (conv),
      .busy     (busy),
      .overrun  (overrun),
      .state    (state)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         latch_cyc = 0;
   int         conv_n = 0;
   logic [7:0] seq = 8'd0;
   logic [7:0] cap_q[$];
   logic [7:0] exp_q[$];
   int         wr_t[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (state == 3'd3) latch_cyc = cyc;
      if (wr) begin
         cap_q.push_back(w_data);
         wr_t.push_back(cyc);
         chk("wr_while_full", 32'(tx_full), 32'd0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Reference: sample as signed integer, code = 8191 - value, big-endian per channel
   function automatic int coded_val(input logic [SW-1:0] x);
      int xs;
      xs = int'(x);
      if (xs >= 8192) xs = xs - 16384;
      return 8191 - xs;
   endfunction

   task automatic model_conv(input logic [SW-1:0] a, input logic [SW-1:0] b);
      conv_n++;
      if (conv_n % DEC == 0) begin
`ifdef ADC_FRAME_HEADER_EN
         exp_q.push_back(8'hA5);
         exp_q.push_back(seq);
         seq = seq + 8'd1;
`endif
         exp_q.push_back(8'(coded_val(a) / 256));
         exp_q.push_back(8'(coded_val(a) % 256));
         exp_q.push_back(8'(coded_val(b) / 256));
         exp_q.push_back(8'(coded_val(b) % 256));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic adc_pulse(input logic [SW-1:0] a, input logic [SW-1:0] b, input int gap);
      ch0_in = a;
      ch1_in = b;
      model_conv(a, b);
      tick();
      end_conv = 1'b1;
      repeat (3) tick();
      end_conv = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic check_queue(input string tag);
      int t = 0;
      while (cap_q.size() < exp_q.size() && t < 5000) begin
         tick();
         t++;
      end
      chk({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && cap_q.size() > 0)
         chk(tag, 32'(cap_q.pop_front()), 32'(exp_q.pop_front()));
      exp_q.delete();
      cap_q.delete();
   endtask

   initial begin
      logic [SW-1:0] edge_tab[8];
      int nconv;
      int t;
      edge_tab = '{14'h0000, 14'h2000, 14'h1FFF, 14'h3FFF, 14'h0001, 14'h2001, 14'h1000, 14'h3000};

      repeat (3) tick();
      chk("rst_state",   32'(state),   32'd0);
      chk("rst_wr",      32'(wr),      32'd0);
      chk("rst_conv",    32'(conv),    32'd0);
      chk("rst_w_data",  32'(w_data),  32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      tick();

      // Start with end_conv already high: level must not trigger
      end_conv = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      conv_n = 0;
      chk("conv_pulse", 32'(conv), 32'd1);
      chk("busy_armed", 32'(busy), 32'd1);
      tick();
      chk("conv_one_cycle", 32'(conv), 32'd0);
      repeat (20) tick();
      chk("level_no_trigger", 32'(state), 32'd2);
      end_conv = 1'b0;
      repeat (3) tick();

      // Known-value frame, latency and strobe spacing
      repeat (DEC - 1) adc_pulse(14'($urandom), 14'($urandom), 25);
      wr_t.delete();
      adc_pulse(14'h0000, 14'h2000, 25);
      for (int i = 1; i < wr_t.size(); i++)
         chk("wr_spacing", 32'(wr_t[i] - wr_t[i-1]), 32'd2);
      if (wr_t.size() > 0) chk("latch_to_wr", 32'(wr_t[0] - latch_cyc), 32'd1);
      else chk("latch_to_wr_seen", 32'd0, 32'd1);
      check_queue("known_frame");

      // tx_full stall with an overrun edge injected during SEND
      tx_full = 1'b1;
      repeat (DEC - 1) adc_pulse(14'($urandom), 14'($urandom), 25);
      adc_pulse(14'($urandom), 14'($urandom), 0);
      chk("stall_in_send", 32'(state), 32'd4);
      repeat (3) tick();
      end_conv = 1'b1;
      tick();
      chk("overrun_set", 32'(overrun), 32'd1);
      end_conv = 1'b0;
      repeat (5) tick();
      chk("no_wr_while_full", 32'(cap_q.size()), 32'd0);
      tx_full = 1'b0;
      check_queue("stall_frame");
      chk("overrun_sticky", 32'(overrun), 32'd1);
      repeat (20) tick();

      // stop mid-frame: frame completes, then IDLE
      repeat (DEC - 1) adc_pulse(14'($urandom), 14'($urandom), 25);
      adc_pulse(14'($urandom), 14'($urandom), 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_queue("stop_frame");
      repeat (3) tick();
      chk("stop_idle",  32'(state), 32'd0);
      chk("stop_busy",  32'(busy),  32'd0);
      nconv = 0;
      repeat (10) begin
         tick();
         if (conv) nconv++;
      end
      chk("stop_conv_quiet", 32'(nconv), 32'd0);
      chk("overrun_in_idle", 32'(overrun), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      conv_n = 0;
      chk("overrun_cleared", 32'(overrun), 32'd0);
      repeat (3) tick();

      // Randomized run, boundary samples first
`ifdef ADC_FRAME_HEADER_EN
      for (int i = 0; i < 257 * DEC; i++) begin
`else
      for (int i = 0; i < 12 * DEC; i++) begin
`endif
         if (i < 8) adc_pulse(edge_tab[i], edge_tab[7 - i], $urandom_range(25, 35));
         else adc_pulse(14'($urandom), 14'($urandom), $urandom_range(25, 35));
      end
      check_queue("random");
      chk("random_no_overrun", 32'(overrun), 32'd0);

      // Reset in the middle of a frame
      repeat (DEC - 1) adc_pulse(14'($urandom), 14'($urandom), 25);
      adc_pulse(14'($urandom), 14'($urandom), 0);
      t = 0;
      while (!wr && t < 50) begin
         tick();
         t++;
      end
      chk("midframe_wr_seen", 32'(wr), 32'd1);
      cap_q.delete();
      exp_q.delete();
      reset = 1'b1;
      #1;
      chk("reset_wr_now",    32'(wr),    32'd0);
      chk("reset_state_now", 32'(state), 32'd0);
      chk("reset_busy_now",  32'(busy),  32'd0);
      repeat (2) tick();
      reset = 1'b0;
      repeat (20) tick();
      chk("reset_no_more_wr", 32'(cap_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
